// File: rtl/llpm_select_pkg.sv
// llpm_select_pkg
// Shared definitions for the LLPM select vertices.
//   - clog2(): constant function used to elaborate the CLog2* parameters.
//   - LLPM_SEL_* localparams: default widths and counts that the select
//     vertices and their arbitration state registers are sized from.
package llpm_select_pkg;

    // Ceiling log2 with a floor of 1, so a one-entry range still gets a bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

    localparam int LLPM_SEL_WIDTH       = 8;
    localparam int LLPM_SEL_NUM_INPUTS  = 4;
    localparam int LLPM_SEL_MAX_BURST   = 4;
    localparam int LLPM_SEL_LAST_W      = clog2(LLPM_SEL_NUM_INPUTS);
    localparam int LLPM_SEL_CNT_W       = clog2(LLPM_SEL_MAX_BURST);

endpackage

// File: rtl/llpm_rr_pick.sv
// llpm_rr_pick
// Combinational rotating priority encoder. Scans x_valid starting one past
// the base index `last`, wrapping modulo NumInputs; `last` itself is scanned
// at the very end so the most recently served input has lowest priority.
// Ports:
//   x_valid   in  NumInputs       request vector
//   last      in  CLog2NumInputs  base index (most recently served input)
//   pick      out CLog2NumInputs  first requesting index after `last`
//   any_valid out 1               OR of x_valid; pick is meaningful only if 1
module llpm_rr_pick
    import llpm_select_pkg::*;
#(
    parameter int NumInputs      = LLPM_SEL_NUM_INPUTS,
    parameter int CLog2NumInputs = clog2(NumInputs)
) (
    input  logic [NumInputs-1:0]      x_valid,
    input  logic [CLog2NumInputs-1:0] last,
    output logic [CLog2NumInputs-1:0] pick,
    output logic                      any_valid
);

    int   idx;
    logic found;

    always_comb begin
        pick  = last;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NumInputs; k++) begin
            idx = (int'(last) + k) % NumInputs;
            if (!found && x_valid[idx[CLog2NumInputs-1:0]]) begin
                pick  = idx[CLog2NumInputs-1:0];
                found = 1'b1;
            end
        end
    end

    assign any_valid = |x_valid;

endmodule

// File: rtl/llpm_select_round_robin.sv
// llpm_select_round_robin
// Fair arbitrated select vertex: merges NumInputs valid/backpressure channels
// onto one output channel. Data and control are purely combinational; the
// only state is arbitration history (last served input, plus burst hold).
//
// Handshake: a channel transfers on a cycle where its valid is 1 and its
// backpressure (bp) is 0. Valid may drop while stalled; nothing is buffered,
// the select simply re-arbitrates in the same cycle.
//
// Ports:
//   clk       in  1                     rising-edge clock
//   resetn    in  1                     synchronous active-low reset
//   x         in  Width x NumInputs     input data (unpacked array)
//   x_valid   in  NumInputs             input valid
//   x_bp      out NumInputs             input backpressure (1 = stall)
//   a         out Width                 output data
//   a_valid   out 1                     output valid
//   a_bp      in  1                     output backpressure
//   a_sel     out CLog2NumInputs        selected input (meaningful when a_valid)
//
// Build option: define LLPM_SELECT_RR_BURST_EN to let a granted input keep
// ownership for up to MaxBurst consecutive transfers. Without it, the grant
// rotates after every transfer and MaxBurst/CLog2MaxBurst have no effect.
module llpm_select_round_robin
    import llpm_select_pkg::*;
#(
    parameter int Width          = LLPM_SEL_WIDTH,
    parameter int NumInputs      = LLPM_SEL_NUM_INPUTS,
    parameter int CLog2NumInputs = clog2(NumInputs),
    parameter int MaxBurst       = LLPM_SEL_MAX_BURST,
    parameter int CLog2MaxBurst  = clog2(MaxBurst)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [Width-1:0]          x [NumInputs],
    input  logic [NumInputs-1:0]      x_valid,
    output logic [NumInputs-1:0]      x_bp,
    output logic [Width-1:0]          a,
    output logic                      a_valid,
    input  logic                      a_bp,
    output logic [CLog2NumInputs-1:0] a_sel
);

    logic [CLog2NumInputs-1:0] last;
    logic                      held;
    logic [CLog2MaxBurst-1:0]  cnt;

    logic [CLog2NumInputs-1:0] pick;
    logic [CLog2NumInputs-1:0] sel;
    logic                      any_valid;
    logic                      keep;
    logic                      fire;

    logic [CLog2NumInputs-1:0] last_d;
    logic                      held_d;
    logic [CLog2MaxBurst-1:0]  cnt_d;

    llpm_rr_pick #(
        .NumInputs      (NumInputs),
        .CLog2NumInputs (CLog2NumInputs)
    ) u_pick (
        .x_valid   (x_valid),
        .last      (last),
        .pick      (pick),
        .any_valid (any_valid)
    );

    // The current owner keeps the grant only while it is still requesting.
    assign keep = held && x_valid[last];
    assign sel  = keep ? last : pick;
    assign fire = resetn && any_valid && !a_bp;

    assign a_valid = resetn && any_valid;
    assign a       = x[sel];
    assign a_sel   = sel;

    always_comb begin
        for (int i = 0; i < NumInputs; i++) begin
            x_bp[i] = !resetn || a_bp
                      || !(any_valid && (sel == CLog2NumInputs'(i)));
        end
    end

    always_comb begin
        last_d = last;
        held_d = held;
        cnt_d  = cnt;
        if (fire) begin
            last_d = sel;
            if (keep) begin
                if (cnt == CLog2MaxBurst'(MaxBurst - 1)) begin
                    held_d = 1'b0;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt + CLog2MaxBurst'(1);
                end
            end else if (MaxBurst > 1) begin
                held_d = 1'b1;
                cnt_d  = CLog2MaxBurst'(1);
            end else begin
                held_d = 1'b0;
                cnt_d  = '0;
            end
        end else if (held && !x_valid[last]) begin
            // Owner released early; last is left pointing at it.
            held_d = 1'b0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last <= CLog2NumInputs'(NumInputs - 1);
        end else begin
            last <= last_d;
        end
    end

`ifdef LLPM_SELECT_RR_BURST_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            held <= 1'b0;
            cnt  <= '0;
        end else begin
            held <= held_d;
            cnt  <= cnt_d;
        end
    end
`else
    // No burst hold: the grant rotates after every transfer.
    assign held = 1'b0;
    assign cnt  = '0;

    logic unused_burst_state;
    assign unused_burst_state = ^{held_d, cnt_d};
`endif

endmodule

// File: tb/tb_llpm_select_round_robin.sv
module tb_llpm_select_round_robin;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int CN  = 2;
    localparam int MB  = 4;
    localparam int CMB = 2;
`ifdef LLPM_SELECT_RR_BURST_EN
    localparam int EFF_BURST = MB;
`else
    localparam int EFF_BURST = 1;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [W-1:0]  x [N];
    logic [N-1:0]  x_valid = '0;
    logic [N-1:0]  x_bp;
    logic [W-1:0]  a;
    logic          a_valid;
    logic          a_bp = 1'b0;
    logic [CN-1:0] a_sel;

    always #5 clk = ~clk;

    llpm_select_round_robin #(
        .Width          (W),
        .NumInputs      (N),
        .CLog2NumInputs (CN),
        .MaxBurst       (MB),
        .CLog2MaxBurst  (CMB)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .x       (x),
        .x_valid (x_valid),
        .x_bp    (x_bp),
        .a       (a),
        .a_valid (a_valid),
        .a_bp    (a_bp),
        .a_sel   (a_sel)
    );

    // ---------------- scoreboard ----------------
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Fairness history: who was served last, and how many consecutive
    // transfers the current grant has made (nonzero = still owns the channel).
    int m_last = N - 1;
    int m_run  = 0;

    function automatic int model_sel(input logic [N-1:0] v);
        int order[$];
        if (m_run > 0 && v[m_last]) return m_last;
        for (int k = 1; k <= N; k++) order.push_back((m_last + k) % N);
        foreach (order[j]) if (v[order[j]]) return order[j];
        return 0;
    endfunction

    // ---------------- driver ----------------
    // One cycle: drive inputs after the falling edge, check outputs, then
    // advance the model to match the coming rising edge.
    task automatic step(input logic rst_n, input logic [N-1:0] v, input logic bp, input int fix2);
        int           es;
        logic         ev;
        logic         efire;
        logic         dfire;
        logic [N-1:0] ebp;
        logic [W-1:0] popped;
        @(negedge clk);
        resetn  = rst_n;
        x_valid = v;
        a_bp    = bp;
        for (int i = 0; i < N; i++) x[i] = W'($urandom_range(0, 255));
        if (fix2 >= 0) x[2] = W'(fix2);
        #1;
        es    = model_sel(v);
        ev    = rst_n && (v != '0);
        efire = ev && !bp;
        ebp   = '1;
        if (efire) ebp[es] = 1'b0;
        check("a_valid", a_valid, ev);
        check("x_bp", x_bp, ebp);
        if (ev) begin
            check("a_sel", a_sel, es);
            check("a_data", a, x[es]);
        end
        if (efire) exp_q.push_back(x[es]);
        dfire = a_valid && !a_bp;
        check("fire", dfire, efire);
        if (dfire && exp_q.size() > 0) begin
            popped = exp_q.pop_front();
            check("sb_data", a, popped);
        end
        if (!rst_n) begin
            m_last = N - 1;
            m_run  = 0;
        end else if (efire) begin
            if (m_run > 0 && v[m_last]) begin
                m_run++;
                if (m_run >= EFF_BURST) m_run = 0;
            end else begin
                m_run = (EFF_BURST > 1) ? 1 : 0;
            end
            m_last = es;
        end else if (m_run > 0 && !v[m_last]) begin
            m_run = 0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < N; i++) x[i] = '0;

        // Reset: idle outputs regardless of inputs.
        step(1'b0, 4'b1111, 1'b0, -1);
        step(1'b0, 4'b0101, 1'b1, -1);

        // All inputs valid, no backpressure: rotation starts at input 0.
        step(1'b1, 4'b1111, 1'b0, -1);
        check("first_grant", a_sel, 0);
        for (int c = 0; c < 11; c++) step(1'b1, 4'b1111, 1'b0, -1);

        // Inputs 1 and 2 only.
        step(1'b0, 4'b0000, 1'b0, -1);
        for (int c = 0; c < 12; c++) step(1'b1, 4'b0110, 1'b0, -1);

        // Input 3 granted, drops after 2 transfers while input 0 waits.
        step(1'b0, 4'b0000, 1'b0, -1);
        step(1'b1, 4'b1000, 1'b0, -1);
        step(1'b1, 4'b1000, 1'b0, -1);
        step(1'b1, 4'b0001, 1'b0, -1);
        check("drop_to_0", a_sel, 0);
        step(1'b1, 4'b1001, 1'b0, -1);

        // Backpressure for 5 cycles with inputs 0 and 2 valid, then release.
        step(1'b0, 4'b0000, 1'b0, -1);
        for (int c = 0; c < 5; c++) step(1'b1, 4'b0101, 1'b1, -1);
        step(1'b1, 4'b0101, 1'b0, -1);
        check("bp_release_0", a_sel, 0);
        step(1'b1, 4'b0101, 1'b0, -1);

        // Single active input: served every cycle, no bubble.
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 4'b0100, 1'b0, 8'hA5);
            check("single_a5", a, 8'hA5);
        end

        // Reset mid-burst with all inputs valid.
        step(1'b1, 4'b1111, 1'b0, -1);
        step(1'b1, 4'b1111, 1'b0, -1);
        step(1'b0, 4'b1111, 1'b0, -1);
        step(1'b1, 4'b1111, 1'b0, -1);
        check("post_reset_grant", a_sel, 0);

        // Randomized traffic with occasional backpressure and reset.
        for (int c = 0; c < 800; c++) begin
            logic [N-1:0] v;
            v = N'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) v = '1;
            step(($urandom_range(0, 99) != 0), v, ($urandom_range(0, 3) == 0), -1);
        end

        check("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
